bit_scan_unit: RTL and testbench

Multi-cycle bit-scan engine in the ALU32 datapath. It latches a 32-bit operand and walks a 5-bit bit index through a single-bit 32:1 select path, one bit per cycle, accumulating the result. Supported operations: population count, find-first-set, find-last-set and parity. It serves the RISC core's multi-cycle bit instructions through a start/busy/done handshake.

---
 rtl/bit_scan_pkg.sv | 30 +++
 rtl/bit_sel32.sv | 12 +
 rtl/bit_scan_unit.sv | 114 +++++++++++
 tb/tb_bit_scan_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared constants, op/state encodings and scan-index helpers for the bit-scan engine.
// Combinational helpers only; no state.
package bit_scan_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  localparam logic [1:0] OP_POPCNT = 2'b00;
  localparam logic [1:0] OP_FFS    = 2'b01;
  localparam logic [1:0] OP_FLS    = 2'b10;
  localparam logic [1:0] OP_PARITY = 2'b11;

  localparam logic [IDX_W-1:0] IDX_MAX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // FLS walks from the MSB down; every other op walks up from bit 0.
  function automatic logic [IDX_W-1:0] scan_first(input logic [1:0] op);
    return (op == OP_FLS) ? IDX_MAX : '0;
  endfunction

  function automatic logic [IDX_W-1:0] scan_last(input logic [1:0] op);
    return (op == OP_FLS) ? '0 : IDX_MAX;
  endfunction

endpackage

// File: rtl/bit_sel32.sv
// Combinational 32:1 single-bit select; zero latency, no handshake.
module bit_sel32
  import bit_scan_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic             bit_o
);

  assign bit_o = data_i[sel_i];

endmodule

// File: rtl/bit_scan_unit.sv
// Multi-cycle POPCNT/FFS/FLS/PARITY engine, one operand bit per cycle; start is ignored while busy.
// Fixed 32 scan cycles; define BIT_SCAN_EARLY_EXIT_EN to end FFS/FLS on the first set bit.
module bit_scan_unit
  import bit_scan_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [5:0]       result_o,
  output logic             found_o
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] operand_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             busy_q, done_q, found_q;
  logic [5:0]       result_q, result_d;
  logic             last_d;
  logic             sel_bit;

  bit_sel32 u_bit_sel32 (
    .data_i (operand_q),
    .sel_i  (idx_q),
    .bit_o  (sel_bit)
  );

  // Next accumulator values include the bit under the index this cycle, so the
  // terminal step can write the final result directly.
  always_comb begin
    cnt_d  = cnt_q + {5'd0, sel_bit};
    par_d  = par_q ^ sel_bit;
    hit_d  = hit_q | sel_bit;
    pos_d  = (!hit_q && sel_bit) ? idx_q : pos_q;
    idx_d  = (op_q == OP_FLS) ? idx_q - 5'd1 : idx_q + 5'd1;
    last_d = (idx_q == scan_last(op_q));
`ifdef BIT_SCAN_EARLY_EXIT_EN
    if ((op_q == OP_FFS || op_q == OP_FLS) && sel_bit) begin
      last_d = 1'b1;
    end
`endif
    case (op_q)
      OP_POPCNT: result_d = cnt_d;
      OP_PARITY: result_d = {5'd0, par_d};
      default:   result_d = hit_d ? {1'b0, pos_d} : 6'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= OP_POPCNT;
      operand_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      hit_q     <= 1'b0;
      pos_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      found_q   <= 1'b0;
    end else begin
      case (state_q)
        S_SCAN: begin
          cnt_q <= cnt_d;
          par_q <= par_d;
          hit_q <= hit_d;
          pos_q <= pos_d;
          if (last_d) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
            found_q  <= hit_d;
          end else begin
            idx_q <= idx_d;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; DONE always pulses exactly once.
          done_q <= 1'b0;
          if (start_i) begin
            state_q   <= S_SCAN;
            busy_q    <= 1'b1;
            op_q      <= op_i;
            operand_q <= operand_i;
            idx_q     <= scan_first(op_i);
            cnt_q     <= '0;
            par_q     <= 1'b0;
            hit_q     <= 1'b0;
            pos_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign found_o  = found_q;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Directed self-checking bench for bit_scan_unit; latency expectations follow BIT_SCAN_EARLY_EXIT_EN.
module tb_bit_scan_unit;
  import bit_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] operand_i = 32'd0;
  logic        busy_o, done_o, found_o;
  logic [5:0]  result_o;

  int n_pass = 0;
  int n_total = 0;

`ifdef BIT_SCAN_EARLY_EXIT_EN
  localparam int LAT_FFS_100 = 9;
  localparam int LAT_FLS_MSB = 1;
  localparam int LAT_FFS_LSB = 32;
  localparam int LAT_FLS_100 = 24;
`else
  localparam int LAT_FFS_100 = 32;
  localparam int LAT_FLS_MSB = 32;
  localparam int LAT_FFS_LSB = 32;
  localparam int LAT_FLS_100 = 32;
`endif
  localparam int LAT_FULL = 32;

  bit_scan_unit dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .operand_i (operand_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .found_o   (found_o)
  );

  always #5 clk = ~clk;

  // Pulses start for one edge, then counts edges until done is seen (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] val,
                        output int lat, output logic busy_ok);
    op_i = op; operand_i = val; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    busy_ok = busy_o;
    lat = 0;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done_o && !busy_o) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
    n_total++; if (result_o !== 6'd0) $display("FAIL reset_result: got %0d want 0", result_o); else n_pass++;
    n_total++; if (found_o !== 1'b0) $display("FAIL reset_found: got %b want 0", found_o); else n_pass++;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL reset_idle_done: got %0d pulses want 0", pulses); else n_pass++;
  endtask

  task automatic test_popcnt();
    int lat; logic bok;
    run_op(OP_POPCNT, 32'hF0F0_0001, lat, bok);
    n_total++; if (lat != LAT_FULL) $display("FAIL popcnt_lat: got %0d want %0d", lat, LAT_FULL); else n_pass++;
    n_total++; if (bok !== 1'b1) $display("FAIL popcnt_busy: busy dropped during scan"); else n_pass++;
    n_total++; if (result_o !== 6'd9) $display("FAIL popcnt_f0f0: got %0d want 9", result_o); else n_pass++;
    n_total++; if (found_o !== 1'b1) $display("FAIL popcnt_found: got %b want 1", found_o); else n_pass++;
    run_op(OP_POPCNT, 32'hFFFF_FFFF, lat, bok);
    n_total++; if (result_o !== 6'd32) $display("FAIL popcnt_all: got %0d want 32", result_o); else n_pass++;
  endtask

  task automatic test_ffs_fls();
    int lat; logic bok;
    run_op(OP_FFS, 32'h0000_0100, lat, bok);
    n_total++; if (result_o !== 6'd8) $display("FAIL ffs_100: got %0d want 8", result_o); else n_pass++;
    n_total++; if (found_o !== 1'b1) $display("FAIL ffs_found: got %b want 1", found_o); else n_pass++;
    n_total++; if (lat != LAT_FFS_100) $display("FAIL ffs_lat: got %0d want %0d", lat, LAT_FFS_100); else n_pass++;
    run_op(OP_FLS, 32'h0000_0100, lat, bok);
    n_total++; if (result_o !== 6'd8) $display("FAIL fls_100: got %0d want 8", result_o); else n_pass++;
    n_total++; if (lat != LAT_FLS_100) $display("FAIL fls_100_lat: got %0d want %0d", lat, LAT_FLS_100); else n_pass++;
    run_op(OP_FLS, 32'h8000_0001, lat, bok);
    n_total++; if (result_o !== 6'd31) $display("FAIL fls_msb: got %0d want 31", result_o); else n_pass++;
    n_total++; if (lat != LAT_FLS_MSB) $display("FAIL fls_msb_lat: got %0d want %0d", lat, LAT_FLS_MSB); else n_pass++;
    run_op(OP_FFS, 32'h8000_0000, lat, bok);
    n_total++; if (result_o !== 6'd31) $display("FAIL ffs_msb: got %0d want 31", result_o); else n_pass++;
    n_total++; if (lat != LAT_FFS_LSB) $display("FAIL ffs_msb_lat: got %0d want %0d", lat, LAT_FFS_LSB); else n_pass++;
  endtask

  task automatic test_zero();
    int lat; logic bok;
    for (int o = 0; o < 4; o++) begin
      run_op(o[1:0], 32'd0, lat, bok);
      n_total++; if (result_o !== 6'd0) $display("FAIL zero_result op%0d: got %0d want 0", o, result_o); else n_pass++;
      n_total++; if (found_o !== 1'b0) $display("FAIL zero_found op%0d: got %b want 0", o, found_o); else n_pass++;
      n_total++; if (lat != LAT_FULL) $display("FAIL zero_lat op%0d: got %0d want %0d", o, lat, LAT_FULL); else n_pass++;
    end
  endtask

  task automatic test_parity();
    int lat; logic bok;
    run_op(OP_PARITY, 32'h0000_0007, lat, bok);
    n_total++; if (result_o !== 6'd1) $display("FAIL parity_7: got %0d want 1", result_o); else n_pass++;
    n_total++; if (found_o !== 1'b1) $display("FAIL parity_found: got %b want 1", found_o); else n_pass++;
    run_op(OP_PARITY, 32'h0000_0003, lat, bok);
    n_total++; if (result_o !== 6'd0) $display("FAIL parity_3: got %0d want 0", result_o); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat = 0;
    logic [5:0] prev;
    prev = result_o;
    op_i = OP_POPCNT; operand_i = 32'h0000_000F; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n_total++; if (result_o !== prev) $display("FAIL hold_on_start: got %0d want %0d", result_o, prev); else n_pass++;
    repeat (5) begin @(posedge clk); #1 lat++; end
    op_i = OP_FFS; operand_i = 32'hFFFF_FFFF; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0; lat++;
    while (!done_o && lat < 100) begin @(posedge clk); #1 lat++; end
    n_total++; if (lat != LAT_FULL) $display("FAIL ignore_lat: got %0d want %0d", lat, LAT_FULL); else n_pass++;
    n_total++; if (result_o !== 6'd4) $display("FAIL ignore_result: got %0d want 4", result_o); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL ignore_idle: got busy %b done %b want 0 0", busy_o, done_o); else n_pass++;
    n_total++; if (result_o !== 6'd4) $display("FAIL result_hold: got %0d want 4", result_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic bok;
    run_op(OP_POPCNT, 32'h0000_0003, lat, bok);
    n_total++; if (done_o !== 1'b1 || result_o !== 6'd2) $display("FAIL b2b_first: got done %b result %0d want 1 2", done_o, result_o); else n_pass++;
    run_op(OP_PARITY, 32'h0000_0007, lat, bok);
    n_total++; if (bok !== 1'b1) $display("FAIL b2b_accept: start in done cycle not accepted"); else n_pass++;
    n_total++; if (lat != LAT_FULL) $display("FAIL b2b_lat: got %0d want %0d", lat, LAT_FULL); else n_pass++;
    n_total++; if (result_o !== 6'd1) $display("FAIL b2b_result: got %0d want 1", result_o); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    op_i = OP_POPCNT; operand_i = 32'h0000_00FF; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    n_total++; if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (result_o !== 6'd0 || found_o !== 1'b0) $display("FAIL midrst_result: got %0d/%b want 0/0", result_o, found_o); else n_pass++;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL midrst_done: got %0d pulses want 0", pulses); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_popcnt();
    test_ffs_fls();
    test_zero();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
